uart_tx_fifo: RTL and testbench

//   Byte-serial debug transmitter that carries internal state out of system_top on one pin.

---
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Debug UART transmitter: a small byte FIFO drained as 8N1 frames, LSB first.
// state | meaning: IDLE line high, pop when FIFO holds data | START start bit | DATA 8 data bits | STOP stop bit
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic [CNT_W-1:0] level,
  output logic             tx,
  output logic             busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]  level_q;
  logic [CNT_W-1:0]  level_d;
  logic              full_q;
  logic              full_d;
  logic [BT_W-1:0]   bt_q;
  logic [2:0]        bi_q;
  logic [7:0]        sh_q;
  logic              tx_q;
  logic              busy_q;
  logic              push;
  logic              pop;
  logic              bt_last;

  // push looks at the registered full, so a same-edge pop never makes room for it
  assign push    = wr_en && !full_q;
  assign pop     = (state_q == IDLE) && (level_q != '0);
  assign bt_last = (bt_q == BT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + CNT_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - CNT_W'(1);
    end
    full_d = (level_d == CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      full_q  <= full_d;
    end
  end

  // tx and busy trail the state by one register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bt_q    <= '0;
      bi_q    <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            sh_q    <= mem_q[rd_ptr_q];
            bt_q    <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (bt_last) begin
            bt_q    <= '0;
            bi_q    <= '0;
            state_q <= DATA;
          end else begin
            bt_q <= bt_q + BT_W'(1);
          end
        end
        DATA: begin
          if (bt_last) begin
            sh_q <= {1'b0, sh_q[7:1]};
            bt_q <= '0;
            if (bi_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bi_q <= bi_q + 3'd1;
            end
          end else begin
            bt_q <= bt_q + BT_W'(1);
          end
        end
        STOP: begin
          if (bt_last) begin
            bt_q    <= '0;
            state_q <= IDLE;
          end else begin
            bt_q <= bt_q + BT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= sh_q[0];
        default: tx_q <= 1'b1;
      endcase
      busy_q <= (state_q != IDLE);
    end
  end

  assign full  = full_q;
  assign level = level_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: receiver model feeds rx_q, expected bytes queued in exp_q as they are written.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full;
  logic [CW-1:0] level;
  logic          tx;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       stop_q[$];
  int         gap_q[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .level(level), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // receiver model: samples mid-bit, one sample per cycle at 1 time unit after the edge
  int         cyc = 0;
  int         rx_cnt = 0;
  int         last_start = 0;
  bit         rx_active = 1'b0;
  bit         have_last = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [2:0] bidx;

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      rx_active = 1'b0;
      have_last = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        if (have_last) gap_q.push_back(cyc - last_start - 10*CPB);
        last_start = cyc;
        have_last  = 1'b1;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && ((rx_cnt - CPB/2) % CPB) == 0) begin
        bidx = 3'((rx_cnt - CPB/2) / CPB - 1);
        rx_byte[bidx] = tx;
      end
      if (rx_cnt == 9*CPB + CPB/2) begin
        rx_q.push_back(rx_byte);
        stop_q.push_back(tx);
        rx_active = 1'b0;
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || level !== '0 || full !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: tx=%b busy=%b level=%0d full=%b want 1 0 0 0", tx, busy, level, full);
      end
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || level !== '0 || full !== 1'b0) begin
        bad++;
        $display("FAIL idle_cycle%0d: tx=%b busy=%b level=%0d full=%b want 1 0 0 0", i, tx, busy, level, full);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    logic [2:0] idx;
    logic       etx;
    logic       ebusy;
    int         k;
    b = 8'hA5;
    rx_q.delete(); stop_q.delete(); exp_q.delete();
    exp_q.push_back(b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
    for (int t = 1; t <= 42; t++) begin
      tick();
      k = t - 2;
      if (t < 2) etx = 1'b1;
      else if (k < CPB) etx = 1'b0;
      else if (k < 9*CPB) begin
        idx = 3'((k - CPB) / CPB);
        etx = b[idx];
      end else etx = 1'b1;
      ebusy = (t >= 2 && t <= 41);
      total++;
      if (tx !== etx || busy !== ebusy) begin
        bad++;
        $display("FAIL frame_a5_t%0d: tx=%b busy=%b want tx=%b busy=%b", t, tx, busy, etx, ebusy);
      end
    end
    total++;
    if (rx_q.size() != 1) begin
      bad++;
      $display("FAIL frame_a5_count: got %0d frames want 1", rx_q.size());
    end else begin
      total++;
      if (rx_q[0] !== exp_q[0] || stop_q[0] !== 1'b1) begin
        bad++;
        $display("FAIL frame_a5_rx: got %h stop=%b want %h stop=1", rx_q[0], stop_q[0], exp_q[0]);
      end
    end
    rx_q.delete(); stop_q.delete(); exp_q.delete();
    repeat (5) tick();
  endtask

  task automatic test_overflow();
    logic [CW-1:0] elvl [5];
    logic          efull [5];
    int            cnt;
    logic [7:0]    r;
    logic          s;
    elvl  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    efull = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rx_q.delete(); stop_q.delete(); exp_q.delete(); gap_q.delete();
    // primer frame keeps the FSM busy so the burst piles up in the FIFO
    exp_q.push_back(8'h00);
    wr_en = 1'b1; wr_data = 8'h00;
    tick();
    wr_en = 1'b0;
    tick();
    total++;
    if (level !== '0) begin
      bad++;
      $display("FAIL ovf_primer_pop: level=%0d want 0", level);
    end
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      if (i < 4) exp_q.push_back(8'(i + 1));
      tick();
      total++;
      if (level !== elvl[i] || full !== efull[i]) begin
        bad++;
        $display("FAIL ovf_write%0d: level=%0d full=%b want %0d %b", i, level, full, elvl[i], efull[i]);
      end
    end
    wr_en = 1'b0;
    cnt = 0;
    while (rx_q.size() < 5 && cnt < 2000) begin tick(); cnt++; end
    repeat (60) tick();
    total++;
    if (rx_q.size() != 5) begin
      bad++;
      $display("FAIL ovf_count: got %0d frames want 5", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      r = rx_q.pop_front(); s = stop_q.pop_front();
      total++;
      if (r !== exp_q[0] || s !== 1'b1) begin
        bad++;
        $display("FAIL ovf_rx: got %h stop=%b want %h stop=1", r, s, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    total++;
    if (gap_q.size() != 5) begin
      bad++;
      $display("FAIL ovf_gap_count: got %0d want 5", gap_q.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        total++;
        if (gap_q[i] != 1) begin
          bad++;
          $display("FAIL ovf_gap%0d: got %0d idle cycles want 1", i, gap_q[i]);
        end
      end
    end
    rx_q.delete(); stop_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    int         cnt;
    int         sent;
    logic [7:0] r;
    rx_q.delete(); stop_q.delete(); exp_q.delete();
    sent = 0;
    while (sent < 10) begin
      for (int j = 0; j < 3 && sent < 10; j++) begin
        wr_en = 1'b1; wr_data = 8'h10 + 8'(sent);
        exp_q.push_back(8'h10 + 8'(sent));
        sent++;
        tick();
      end
      wr_en = 1'b0;
      cnt = 0;
      while (rx_q.size() < sent && cnt < 2000) begin tick(); cnt++; end
      total++;
      if (rx_q.size() < sent) begin
        bad++;
        $display("FAIL wrap_timeout: got %0d frames want %0d", rx_q.size(), sent);
      end
      repeat (5) tick();
    end
    total++;
    if (rx_q.size() != 10) begin
      bad++;
      $display("FAIL wrap_count: got %0d frames want 10", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      r = rx_q.pop_front();
      total++;
      if (r !== exp_q[0]) begin
        bad++;
        $display("FAIL wrap_order: got %h want %h", r, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    rx_q.delete(); stop_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int cnt;
    rx_q.delete(); stop_q.delete(); exp_q.delete();
    wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    repeat (9) tick();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || level !== '0 || busy !== 1'b0 || full !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: tx=%b level=%0d busy=%b full=%b want 1 0 0 0", tx, level, busy, full);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (tx !== 1'b1) begin
        bad++;
        $display("FAIL rst_glitch%0d: tx=%b want 1", i, tx);
      end
    end
    #1 rst_n = 1'b1;
    repeat (3) tick();
    exp_q.push_back(8'h3C);
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    cnt = 0;
    while (rx_q.size() < 1 && cnt < 2000) begin tick(); cnt++; end
    repeat (60) tick();
    total++;
    if (rx_q.size() != 1) begin
      bad++;
      $display("FAIL rst_after_count: got %0d frames want 1", rx_q.size());
    end else begin
      total++;
      if (rx_q[0] !== exp_q[0] || stop_q[0] !== 1'b1) begin
        bad++;
        $display("FAIL rst_after_rx: got %h stop=%b want %h stop=1", rx_q[0], stop_q[0], exp_q[0]);
      end
    end
    rx_q.delete(); stop_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_same_edge();
    int         cnt;
    logic [7:0] r;
    rx_q.delete(); stop_q.delete(); exp_q.delete();
    exp_q.push_back(8'h60);
    wr_en = 1'b1; wr_data = 8'h60;
    tick();
    for (int t = 1; t <= 4; t++) begin
      wr_data = 8'h60 + 8'(t);
      exp_q.push_back(8'h60 + 8'(t));
      tick();
    end
    wr_en = 1'b0;
    total++;
    if (level !== 3'd4 || full !== 1'b1) begin
      bad++;
      $display("FAIL same_fill: level=%0d full=%b want 4 1", level, full);
    end
    // first frame's STOP ends on relative edge 41, so the pop happens on edge 42
    repeat (37) tick();
    total++;
    if (level !== 3'd4 || full !== 1'b1) begin
      bad++;
      $display("FAIL same_pre: level=%0d full=%b want 4 1", level, full);
    end
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    total++;
    if (level !== 3'd3 || full !== 1'b0) begin
      bad++;
      $display("FAIL same_edge: level=%0d full=%b want 3 0", level, full);
    end
    cnt = 0;
    while (rx_q.size() < 5 && cnt < 2000) begin tick(); cnt++; end
    repeat (60) tick();
    total++;
    if (rx_q.size() != 5) begin
      bad++;
      $display("FAIL same_count: got %0d frames want 5", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      r = rx_q.pop_front();
      total++;
      if (r !== exp_q[0]) begin
        bad++;
        $display("FAIL same_order: got %h want %h", r, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_wrap();
    test_reset_mid_frame();
    test_full_same_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
